psec6_spi_regbank: RTL and testbench



---
 rtl/psec6_spi_pkg.sv | 34 +++
 rtl/psec6_spi_regbank_shifter.sv | 30 +++
 rtl/psec6_spi_regbank.sv | 171 +++++++++++++++++
 tb/tb_psec6_spi_regbank.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/psec6_spi_pkg.sv
// Shared types and constants for the PSEC6 SPI register bank.
package psec6_spi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_DATA = 2'd2
   } spi_state_t;

   // Header byte layout: bit 7 selects write (1) or read (0); the start
   // address sits in the low ADDR_W bits, anything in between is ignored.
   localparam int unsigned HDR_RW_BIT   = 7;
   localparam int unsigned HDR_ADDR_LSB = 0;

   localparam int unsigned MAX_REGS = 128;

   // Power-on contents per address; instruction and status slots hold 0.
   localparam logic [7:0] REG_RST_VAL [MAX_REGS] = '{
      0:  8'hA5,
      1:  8'h10,
      2:  8'h20,
      3:  8'h00,
      4:  8'h44,
      5:  8'h55,
      6:  8'h66,
      7:  8'h77,
      8:  8'h88,
      9:  8'h99,
      10: 8'h00,
      11: 8'hC3,
      default: 8'h00
   };

endpackage

// File: rtl/psec6_spi_regbank_shifter.sv
// Input side of the SPI slave: bit counter and MSB-first shift register.
// byte_done is high during the cycle whose rising edge samples the 8th bit,
// and byte_val is the complete byte including that bit.
module spi_byte_shifter (
   input  logic       spi_clk,
   input  logic       rstn,
   input  logic       cs,
   input  logic       pico,
   output logic [7:0] byte_val,
   output logic       byte_done
);

   logic [2:0] bit_cnt;
   logic [6:0] sreg;

   // Count and shift one bit per edge; a cs rise drops any partial byte.
   always_ff @(posedge spi_clk or negedge rstn or posedge cs) begin
      if (!rstn || cs) begin
         bit_cnt <= '0;
         sreg    <= '0;
      end else begin
         bit_cnt <= bit_cnt + 3'd1;
         sreg    <= {sreg[5:0], pico};
      end
   end

   assign byte_done = (bit_cnt == 3'd7);
   assign byte_val  = {sreg, pico};

endmodule

// File: rtl/psec6_spi_regbank.sv
// PSEC6 SPI register bank: header + auto-incrementing data burst, flat
// register outputs, write strobes, instruction pulses and readback.
// Readback shifter is built only when PSEC6_SPI_READBACK_EN is defined.
module psec6_spi_regbank
   import psec6_spi_pkg::*;
#(
   parameter int unsigned ADDR_W      = 4,
   parameter int unsigned NUM_REGS    = 12,
   parameter int unsigned INST_ADDR   = 3,
   parameter int unsigned STATUS_ADDR = 10,
   parameter int unsigned NUM_INST    = 4
) (
   input  logic                  spi_clk,
   input  logic                  rstn,
   input  logic                  cs,
   input  logic                  pico,
   output logic                  poci,
   input  logic [7:0]            status_in,
   output logic [8*NUM_REGS-1:0] regs_flat,
   output logic [NUM_REGS-1:0]   wr_strobe,
   output logic [NUM_INST-1:0]   inst_pulse,
   output logic                  frame_active
);

   localparam int unsigned PTR_W = ADDR_W + 1;
   localparam logic [PTR_W-1:0] INST_A = PTR_W'(INST_ADDR);
   localparam logic [PTR_W-1:0] STAT_A = PTR_W'(STATUS_ADDR);
   localparam logic [PTR_W-1:0] NREG   = PTR_W'(NUM_REGS);
   localparam logic [PTR_W-1:0] LAST_A = PTR_W'(NUM_REGS - 1);

   spi_state_t          state;
   logic                is_write;
   logic [PTR_W-1:0]    ptr;
   logic [PTR_W-1:0]    ptr_next;
   logic [7:0]          regs [NUM_REGS];
   logic [7:0]          byte_val;
   logic                byte_done;
   logic [NUM_REGS-1:0] reg_we;
   logic                inst_hit;

   spi_byte_shifter u_shifter (
      .spi_clk   (spi_clk),
      .rstn      (rstn),
      .cs        (cs),
      .pico      (pico),
      .byte_val  (byte_val),
      .byte_done (byte_done)
   );

   assign ptr_next = (ptr == LAST_A) ? '0 : ptr + PTR_W'(1);

   // Frame FSM: header capture and address pointer; cs high aborts the frame.
   always_ff @(posedge spi_clk or negedge rstn or posedge cs) begin
      if (!rstn || cs) begin
         state        <= ST_IDLE;
         frame_active <= 1'b0;
         is_write     <= 1'b0;
         ptr          <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               state        <= ST_HDR;
               frame_active <= 1'b1;
            end
            ST_HDR: begin
               if (byte_done) begin
                  state    <= ST_DATA;
                  is_write <= byte_val[HDR_RW_BIT];
                  ptr      <= {1'b0, byte_val[HDR_ADDR_LSB +: ADDR_W]};
               end
            end
            ST_DATA: begin
               if (byte_done) ptr <= ptr_next;
            end
            default: begin
               state        <= ST_IDLE;
               frame_active <= 1'b0;
            end
         endcase
      end
   end

   // Decode a completed write byte into a register enable or instruction hit.
   always_comb begin
      reg_we   = '0;
      inst_hit = 1'b0;
      if (state == ST_DATA && byte_done && is_write) begin
         if (ptr == INST_A) begin
            inst_hit = 1'b1;
         end else if (ptr != STAT_A && ptr < NREG) begin
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
               if (ptr == PTR_W'(k)) reg_we[k] = 1'b1;
            end
         end
      end
   end

   // Register file; only rstn resets it, a cs rise leaves contents alone.
   always_ff @(posedge spi_clk or negedge rstn) begin
      if (!rstn) begin
         for (int unsigned k = 0; k < NUM_REGS; k++) regs[k] <= REG_RST_VAL[k];
      end else begin
         for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (reg_we[k]) regs[k] <= byte_val;
         end
      end
   end

   // One-cycle commit pulses, cut short asynchronously by cs.
   always_ff @(posedge spi_clk or negedge rstn or posedge cs) begin
      if (!rstn || cs) begin
         wr_strobe  <= '0;
         inst_pulse <= '0;
      end else begin
         wr_strobe  <= reg_we;
         inst_pulse <= inst_hit ? byte_val[NUM_INST-1:0] : '0;
      end
   end

   // Flatten the register file for the clock and channel logic.
   always_comb begin
      regs_flat = '0;
      for (int unsigned k = 0; k < NUM_REGS; k++) regs_flat[8*k +: 8] = regs[k];
   end

`ifdef PSEC6_SPI_READBACK_EN
   logic [7:0]       out_sr;
   logic [7:0]       rd_byte;
   logic [PTR_W-1:0] rd_addr;
   logic             hdr_read_done;
   logic             data_read_done;

   assign hdr_read_done  = (state == ST_HDR) && byte_done && !byte_val[HDR_RW_BIT];
   assign data_read_done = (state == ST_DATA) && byte_done && !is_write;
   // The header edge loads the start address; later loads use the pointer
   // value it is about to advance to.
   assign rd_addr = hdr_read_done ? {1'b0, byte_val[HDR_ADDR_LSB +: ADDR_W]} : ptr_next;

   // Select the byte returned for the address being loaded.
   always_comb begin
      rd_byte = '0;
      if (rd_addr == INST_A) begin
         rd_byte = '0;
      end else if (rd_addr == STAT_A) begin
         rd_byte = status_in;
      end else if (rd_addr < NREG) begin
         for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (rd_addr == PTR_W'(k)) rd_byte = regs[k];
         end
      end
   end

   // Output shifter: load at each byte boundary of a read, shift otherwise.
   always_ff @(posedge spi_clk or negedge rstn or posedge cs) begin
      if (!rstn || cs) begin
         out_sr <= '0;
      end else if (hdr_read_done || data_read_done) begin
         out_sr <= rd_byte;
      end else if (state == ST_DATA && !is_write) begin
         out_sr <= {out_sr[6:0], 1'b0};
      end
   end

   assign poci = out_sr[7];
`else
   logic unused_status;
   assign unused_status = ^status_in;
   assign poci = 1'b0;
`endif

endmodule

// File: tb/tb_psec6_spi_regbank.sv
// Self-checking bench for psec6_spi_regbank (default parameters).
// Expected readback follows PSEC6_SPI_READBACK_EN the same way the design does.
module tb_psec6_spi_regbank;

   localparam int NR   = 12;
   localparam int AW   = 4;
   localparam int INST = 3;
   localparam int STAT = 10;
   localparam int NI   = 4;
`ifdef PSEC6_SPI_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif

   logic            spi_clk = 1'b0;
   logic            rstn, cs, pico;
   logic            poci;
   logic [7:0]      status_in;
   logic [8*NR-1:0] regs_flat;
   logic [NR-1:0]   wr_strobe;
   logic [NI-1:0]   inst_pulse;
   logic            frame_active;

   psec6_spi_regbank #(
      .ADDR_W      (AW),
      .NUM_REGS    (NR),
      .INST_ADDR   (INST),
      .STATUS_ADDR (STAT),
      .NUM_INST    (NI)
   ) dut (
      .spi_clk      (spi_clk),
      .rstn         (rstn),
      .cs           (cs),
      .pico         (pico),
      .poci         (poci),
      .status_in    (status_in),
      .regs_flat    (regs_flat),
      .wr_strobe    (wr_strobe),
      .inst_pulse   (inst_pulse),
      .frame_active (frame_active)
   );

   always #5 spi_clk = ~spi_clk;

   int checks = 0;
   int errors = 0;

   // Independent copy of the power-on register contents.
   logic [7:0] rst_tab [NR] = '{8'hA5, 8'h10, 8'h20, 8'h00, 8'h44, 8'h55,
                                8'h66, 8'h77, 8'h88, 8'h99, 8'h00, 8'hC3};

   logic [7:0]      exp_regs [NR];
   logic [NR-1:0]   exp_wr;
   logic [NI-1:0]   exp_inst;
   logic            exp_poci;
   logic            exp_active;
   logic [8*NR-1:0] exp_flat;
   bit              chk_en = 1'b0;

   logic [7:0] fb [$];
   bit         m_write;
   int         m_addr;
   logic [15:0] rx;
   int         cnt_wr1, cnt_wr2, cnt_inst3, cnt_any_wr;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   function automatic logic [7:0] rdval(input int a);
      if (a == INST) return 8'h00;
      if (a == STAT) return status_in;
      if (a < NR) return exp_regs[a];
      return 8'h00;
   endfunction

   task automatic reset_model();
      for (int k = 0; k < NR; k++) exp_regs[k] = rst_tab[k];
      exp_wr = '0; exp_inst = '0; exp_poci = 1'b0; exp_active = 1'b0;
   endtask

   task automatic apply_write(input int a, input logic [7:0] d);
      if (a == INST) exp_inst = d[NI-1:0];
      else if (a != STAT && a < NR) begin
         exp_regs[a] = d;
         exp_wr[a] = 1'b1;
      end
   endtask

   // Effect of frame bit n (0 = header MSB) on the visible outputs.
   task automatic model_edge(input int n);
      int k, j;
      logic [7:0] hdr, v;
      k = n / 8;
      j = n % 8;
      exp_wr = '0; exp_inst = '0; exp_active = 1'b1;
      if (k == 0) begin
         exp_poci = 1'b0;
         if (j == 7) begin
            hdr = fb[0];
            m_write = hdr[7];
            m_addr = int'(hdr) % (1 << AW);
            v = rdval(m_addr);
            exp_poci = (!m_write && RB) ? v[7] : 1'b0;
         end
      end else if (j < 7) begin
         v = rdval(m_addr);
         exp_poci = (!m_write && RB) ? v[6-j] : 1'b0;
      end else begin
         if (m_write) apply_write(m_addr, fb[k]);
         m_addr = (m_addr == NR - 1) ? 0 : m_addr + 1;
         v = rdval(m_addr);
         exp_poci = (!m_write && RB) ? v[7] : 1'b0;
      end
   endtask

   // Clock nbits of fb through one frame; optionally pulse rstn before cs rises.
   task automatic frame(input int nbits, input bit rst_mid);
      logic [7:0] b;
      rx = '0;
      @(negedge spi_clk);
      cs = 1'b0;
      for (int n = 0; n < nbits; n++) begin
         b = fb[n/8];
         pico = b[7 - n%8];
         @(posedge spi_clk);
         model_edge(n);
         @(negedge spi_clk);
         if (n >= 7 && n <= nbits - 2) rx = {rx[14:0], poci};
      end
      if (rst_mid) begin
         rstn = 1'b0;
         reset_model();
         @(negedge spi_clk);
      end
      cs = 1'b1;
      pico = 1'b0;
      exp_wr = '0; exp_inst = '0; exp_active = 1'b0; exp_poci = 1'b0;
      if (rst_mid) begin
         @(negedge spi_clk);
         rstn = 1'b1;
      end
   endtask

   task automatic clr_counts();
      cnt_wr1 = 0; cnt_wr2 = 0; cnt_inst3 = 0; cnt_any_wr = 0;
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(posedge spi_clk);
         #1;
         if (chk_en) begin
            for (int k = 0; k < NR; k++) exp_flat[8*k +: 8] = exp_regs[k];
            chk("regs_flat", regs_flat, exp_flat);
            chk("wr_strobe", wr_strobe, exp_wr);
            chk("inst_pulse", inst_pulse, exp_inst);
            chk("poci", poci, exp_poci);
            chk("frame_active", frame_active, exp_active);
            if (wr_strobe[1]) cnt_wr1++;
            if (wr_strobe[2]) cnt_wr2++;
            if (inst_pulse == 4'h3) cnt_inst3++;
            if (wr_strobe != '0) cnt_any_wr++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rstn = 1'b1; cs = 1'b1; pico = 1'b0; status_in = 8'h01;
      clr_counts();
      #2 rstn = 1'b0;
      reset_model();
      chk_en = 1'b1;
      #20;
      chk("rst_reg0", regs_flat[7:0], 8'hA5);
      chk("rst_reg11", regs_flat[95:88], 8'hC3);
      chk("rst_strobe", wr_strobe, 12'h000);
      chk("rst_poci", poci, 1'b0);
      @(negedge spi_clk);
      rstn = 1'b1;

      // Write burst through the instruction slot.
      clr_counts();
      fb = '{8'h81, 8'h11, 8'h22, 8'h33};
      frame(32, 1'b0);
      chk("burst_reg1", regs_flat[15:8], 8'h11);
      chk("burst_reg2", regs_flat[23:16], 8'h22);
      chk("burst_reg3", regs_flat[31:24], 8'h00);
      chk("burst_wr1_cycles", cnt_wr1, 1);
      chk("burst_wr2_cycles", cnt_wr2, 1);
      chk("burst_inst_cycles", cnt_inst3, 1);

      // Address wrap from the last register back to 0.
      fb = '{8'h8B, 8'hAA, 8'h55};
      frame(24, 1'b0);
      chk("wrap_reg11", regs_flat[95:88], 8'hAA);
      chk("wrap_reg0", regs_flat[7:0], 8'h55);

      // Readback of status then reg11.
      status_in = 8'h01;
      fb = '{8'h0A, 8'h00, 8'h00};
      frame(24, 1'b0);
      chk("read_stream", rx, RB ? 16'h01AA : 16'h0000);

      // Aborted partial byte, then a clean retry.
      clr_counts();
      fb = '{8'h82, 8'hFF};
      frame(13, 1'b0);
      chk("abort_reg2", regs_flat[23:16], 8'h22);
      chk("abort_no_strobe", cnt_any_wr, 0);
      fb = '{8'h82, 8'h7E};
      frame(16, 1'b0);
      chk("retry_reg2", regs_flat[23:16], 8'h7E);

      // Reset during the second data byte, then a fresh frame.
      fb = '{8'h84, 8'h12, 8'h34, 8'h56};
      frame(20, 1'b1);
      chk("rstmid_reg4", regs_flat[39:32], 8'h44);
      chk("rstmid_reg2", regs_flat[23:16], 8'h20);
      chk("rstmid_idle", frame_active, 1'b0);
      fb = '{8'h85, 8'h9C};
      frame(16, 1'b0);
      chk("after_rst_reg5", regs_flat[47:40], 8'h9C);

      // Status slot ignores writes; burst continues into reg11.
      fb = '{8'h8A, 8'hEE, 8'h5A};
      frame(24, 1'b0);
      chk("status_wr_ign", regs_flat[95:88], 8'h5A);

      // Out-of-range start address has no effect.
      fb = '{8'h8E, 8'hFF, 8'hFF};
      frame(24, 1'b0);

      // Read with a different status value and reg0 following reg11.
      status_in = 8'h80;
      fb = '{8'h0A, 8'h00, 8'h00, 8'h00};
      frame(32, 1'b0);
      chk("read_reg0_tail", rx, RB ? 16'h5AA5 : 16'h0000);

      repeat (3) @(negedge spi_clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
